// File: rtl/hammer_stim_misr.sv
// rtl/hammer_stim_misr.sv - LFSR stimulus driver with MISR signature capture (optional corner vectors via HAMMER_CORNER_EN)
module hammer_stim_misr #(
    parameter int          WIDTH_A   = 8,
    parameter int          WIDTH_Y   = 16,
    parameter logic [31:0] LFSR_SEED = 32'h00000001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        count,
    input  logic [31:0]        exp_sig,
    output logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_Y-1:0] y,
    output logic               busy,
    output logic               done,
    output logic [31:0]        sig,
    output logic               pass
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h00000001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] remaining;
    logic [31:0] lfsr;
    logic [31:0] sig_next;
    logic        fb;

`ifdef HAMMER_CORNER_EN
    localparam logic [WIDTH_A-1:0] VEC_ONES = '1;
    localparam logic [WIDTH_A-1:0] VEC_LOW  = VEC_ONES >> 1;
    localparam logic [WIDTH_A-1:0] VEC_MSB  = ~VEC_LOW;

    // Index of the next corner vector to drive; 4 means corners are exhausted.
    logic [2:0] corner_idx;

    function automatic logic [WIDTH_A-1:0] corner_vec(input logic [1:0] idx);
        case (idx)
            2'd0:    return '0;
            2'd1:    return VEC_ONES;
            2'd2:    return VEC_MSB;
            default: return VEC_LOW;
        endcase
    endfunction
`endif

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'hA3000000 : 32'h00000000);
    endfunction

    // MISR fold of the current response; y is always zero-extended.
    always_comb begin
        fb       = sig[31] ^ sig[21] ^ sig[1] ^ sig[0];
        sig_next = {sig[30:0], fb} ^ 32'(y);
    end

    assign pass = done && (sig == exp_sig);

    // Run sequencer: vector generation, signature folding and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a          <= '0;
            sig        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            lfsr       <= SEED;
`ifdef HAMMER_CORNER_EN
            corner_idx <= 3'd0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sig <= '0;
                        if (count == 16'd0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            lfsr  <= SEED;
`ifdef HAMMER_CORNER_EN
                            corner_idx <= 3'd0;
`endif
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                            remaining <= count;
`ifdef HAMMER_CORNER_EN
                            // Vector 0 is the all-zeros corner; the LFSR is untouched.
                            a          <= corner_vec(2'd0);
                            corner_idx <= 3'd1;
                            lfsr       <= SEED;
`else
                            // Vector 0 consumes the seed, so the LFSR steps past it.
                            a    <= SEED[WIDTH_A-1:0];
                            lfsr <= lfsr_step(SEED);
`endif
                        end
                    end
                end
                RUN: begin
                    sig       <= sig_next;
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
`ifdef HAMMER_CORNER_EN
                        if (corner_idx < 3'd4) begin
                            a          <= corner_vec(corner_idx[1:0]);
                            corner_idx <= corner_idx + 3'd1;
                        end else begin
                            a    <= lfsr[WIDTH_A-1:0];
                            lfsr <= lfsr_step(lfsr);
                        end
`else
                        a    <= lfsr[WIDTH_A-1:0];
                        lfsr <= lfsr_step(lfsr);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hammer_stim_misr.sv
// tb/tb_hammer_stim_misr.sv - directed bench for hammer_stim_misr
module tb_hammer_stim_misr;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] count;
    logic [31:0] exp_sig;
    logic [7:0]  a;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [31:0] sig;
    logic        pass;
    logic        lb;

    int vectors = 0;
    int miscompares = 0;
    int bcnt;

    always #5 clk = ~clk;

    always_comb y = lb ? {8'h00, a} : 16'h0000;

    hammer_stim_misr #(
        .WIDTH_A  (8),
        .WIDTH_Y  (16),
        .LFSR_SEED(32'h00000001)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .count  (count),
        .exp_sig(exp_sig),
        .a      (a),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .sig    (sig),
        .pass   (pass)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; count = 16'd0; exp_sig = 32'h0; lb = 1'b0;
        step();
        rst = 1'b0;
        check("reset_a", 32'(a), 32'h0);
        check("reset_sig", sig, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_pass", 32'(pass), 32'h0);

`ifdef HAMMER_CORNER_EN
        // Corner vectors then LFSR values from the seed.
        count = 16'd6; start = 1'b1;
        step();
        start = 1'b0;
        check("corner_a0", 32'(a), 32'h00); step();
        check("corner_a1", 32'(a), 32'hFF); step();
        check("corner_a2", 32'(a), 32'h80); step();
        check("corner_a3", 32'(a), 32'h7F); step();
        check("corner_a4", 32'(a), 32'h01); step();
        check("corner_a5", 32'(a), 32'h00);
        check("corner_busy5", 32'(busy), 32'h1);
        step();
        check("corner_done", 32'(done), 32'h1);
        check("corner_busy_end", 32'(busy), 32'h0);
`else
        // y tied to zero, single vector.
        count = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("c1_a", 32'(a), 32'h01);
        check("c1_busy", 32'(busy), 32'h1);
        check("c1_done_run", 32'(done), 32'h0);
        step();
        check("c1_busy_end", 32'(busy), 32'h0);
        check("c1_done", 32'(done), 32'h1);
        check("c1_sig", sig, 32'h0);
        check("c1_pass", 32'(pass), 32'h1);
        check("c1_a_hold", 32'(a), 32'h01);

        // Loopback, three vectors.
        lb = 1'b1; exp_sig = 32'h00000006; count = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("c3_a0", 32'(a), 32'h01);
        check("c3_busy0", 32'(busy), 32'h1);
        step();
        check("c3_a1", 32'(a), 32'h00);
        check("c3_busy1", 32'(busy), 32'h1);
        step();
        check("c3_a2", 32'(a), 32'h00);
        check("c3_busy2", 32'(busy), 32'h1);
        step();
        check("c3_done", 32'(done), 32'h1);
        check("c3_sig", sig, 32'h00000006);
        check("c3_pass", 32'(pass), 32'h1);
        exp_sig = 32'h00000007;
        #1;
        check("c3_pass_wrong_exp", 32'(pass), 32'h0);
        step();
        check("c3_sig_hold", sig, 32'h00000006);

        // Loopback single vector leaves a=01 and sig=1 for the count=0 check.
        count = 16'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("c1lb_sig", sig, 32'h00000001);
        check("c1lb_a", 32'(a), 32'h01);

        // count=0: straight to DONE, sig cleared, a unchanged.
        exp_sig = 32'h0; count = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("c0_done", 32'(done), 32'h1);
        check("c0_busy", 32'(busy), 32'h0);
        check("c0_sig", sig, 32'h0);
        check("c0_a", 32'(a), 32'h01);
        check("c0_pass", 32'(pass), 32'h1);
        step();
        check("c0_busy_hold", 32'(busy), 32'h0);
        check("c0_done_hold", 32'(done), 32'h1);

        // count=5 with start re-pulsed during RUN cycle 2.
        count = 16'd5; start = 1'b1;
        step();
        start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) bcnt++;
            if (i == 1) begin
                start = 1'b1;
                count = 16'd2;
            end else begin
                start = 1'b0;
            end
            step();
        end
        check("c5_busy_cycles", 32'(bcnt), 32'd5);
        check("c5_done", 32'(done), 32'h1);
        check("c5_sig", sig, 32'h0000001B);

        // Reset in RUN cycle 3 of a count=10 run.
        count = 16'd10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("c10_busy_pre_rst", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_busy", 32'(busy), 32'h0);
        check("rst_run_done", 32'(done), 32'h0);
        check("rst_run_sig", sig, 32'h0);
        check("rst_run_a", 32'(a), 32'h0);
        step();
        check("rst_idle_busy", 32'(busy), 32'h0);

        // Restart after reset begins at vector 0 again.
        count = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("restart_a0", 32'(a), 32'h01);
        bcnt = 0;
        while (!done && bcnt < 10) begin
            step();
            bcnt++;
        end
        check("restart_done", 32'(done), 32'h1);
        check("restart_sig", sig, 32'h00000006);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hammer_stim_misr.md
HAMMER_STIM_MISR -- requirements
Module: hammer_stim_misr

Interface
REQ-001 SHALL have parameter WIDTH_A, default 8, stimulus width (1..32).
REQ-002 SHALL have parameter WIDTH_Y, default 16, DUT response width (1..32).
REQ-003 SHALL have parameter LFSR_SEED, default 32'h00000001, LFSR reload value; a value of 0 SHALL be treated as 32'h00000001.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, run request, sampled in IDLE or DONE only.
REQ-007 SHALL have port count, input, 16, number of vectors for the run, sampled with start.
REQ-008 SHALL have port exp_sig, input, 32, expected signature, compared continuously.
REQ-009 SHALL have port a, output, WIDTH_A, registered stimulus to the combinational DUT.
REQ-010 SHALL have port y, input, WIDTH_Y, combinational DUT response to a.
REQ-011 SHALL have port busy, output, 1, high in RUN.
REQ-012 SHALL have port done, output, 1, high in DONE.
REQ-013 SHALL have port sig, output, 32, MISR signature.
REQ-014 SHALL have port pass, output, 1, defined as done AND (sig == exp_sig).

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-016 IDLE/DONE with start=1 and count=0 SHALL go to DONE next cycle, with sig cleared to 0, lfsr reloaded and a unchanged.
REQ-017 IDLE/DONE with start=1 and count>0 SHALL, on that edge: load remaining=count, reload lfsr, clear sig, drive a=vector 0, and go to RUN.
REQ-018 Each RUN edge SHALL fold the current y into sig and decrement remaining.
REQ-019 If remaining==1 at a RUN edge, the FSM SHALL go to DONE and hold a; otherwise a SHALL advance to the next vector.
REQ-020 RUN SHALL last exactly count cycles, and each vector SHALL be folded exactly once, in the cycle after it is driven.
REQ-021 start during RUN SHALL be ignored.
REQ-022 DONE SHALL hold sig, a and done until the next accepted start or rst.
REQ-023 LFSR: Galois, right shift, lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 32'hA3000000 : 0).
REQ-024 The LFSR vector SHALL be a = lfsr[WIDTH_A-1:0], and the LFSR SHALL advance only when its value is consumed.
REQ-025 MISR: fb = sig[31]^sig[21]^sig[1]^sig[0]; sig_next = {sig[30:0],fb} ^ zero-extend(y) to 32 bits.
REQ-026 All arithmetic SHALL be unsigned; y SHALL never be sign-extended.
REQ-027 remaining SHALL be 16 bits, so count=16'hFFFF gives 65535 RUN cycles with no wrap.

Reset
REQ-028 rst SHALL take priority over start in every state, including mid-RUN.
REQ-029 On the next edge after rst=1, the block SHALL be in IDLE with a=0, sig=0, busy=0, done=0, pass=0, remaining=0 and lfsr=LFSR_SEED.

Configuration
REQ-030 The macro HAMMER_CORNER_EN SHALL control corner vectors.
REQ-031 With HAMMER_CORNER_EN defined, vectors 0..3 SHALL be all-zeros, all-ones, MSB-only and all-ones-except-MSB; vector 4 onward SHALL be LFSR values starting at the seed.
REQ-032 With HAMMER_CORNER_EN defined and count<4, only the first count corner vectors SHALL be driven.
REQ-033 With HAMMER_CORNER_EN undefined, vector 0 SHALL be the seed's LFSR value and all vectors SHALL come from the LFSR.
REQ-034 The corner-vector counter SHALL be absent from the RTL when HAMMER_CORNER_EN is undefined.

Verification (WIDTH_A=8, WIDTH_Y=16, LFSR_SEED=1, macro undefined unless stated)
REQ-035 Bench SHALL cover: y tied 0, count=1, start -> a=8'h01, one busy cycle, then done=1, sig=32'h00000000.
REQ-036 Bench SHALL cover: y={8'h00,a} loopback, count=3 -> a sequence 8'h01,8'h00,8'h00, sig=32'h00000006, and pass=1 when exp_sig=32'h00000006.
REQ-037 Bench SHALL cover: count=0, start -> done=1 next cycle, busy never high, sig=0, a unchanged.
REQ-038 Bench SHALL cover: count=5 with start pulsed again in RUN cycle 2 -> busy high for exactly 5 cycles, and the signature equals that of an undisturbed run.
REQ-039 Bench SHALL cover: rst=1 in RUN cycle 3 of count=10 -> next cycle IDLE, busy=0, done=0, sig=0, a=0; a new start restarts at vector 0.
REQ-040 Bench SHALL cover: HAMMER_CORNER_EN defined, count=6 -> a sequence 8'h00,8'hFF,8'h80,8'h7F,8'h01,8'h00.
